simon_param: RTL and testbench
==============================

# simon_param

Parametrised Simon block cipher core with a fixed 4-word key (Simon 32/64, 48/96, 64/128) that runs both encryption and decryption. Block and key are loaded serially through a 4-bit nibble port and the result is read out the same way. A start/busy/done handshake and a state machine run the rounds. For decryption the core first runs the key schedule forward, then replays it backwards. It replaces the fixed 32/64 encrypt-only core in the 8-bit-IO wrapper.

## Interface

- `WORD`, default 16: word size n in bits. Legal values are 16, 24 and 32. The block is 2·WORD bits and the key is 4·WORD bits.
- `ROUNDS`, default 32: round count T. Use 32 for n=16, 36 for n=24, 44 for n=32.
- `Z_SEQ`, default z0: 62-bit Simon constant sequence. Bit j is element j. Use z0 for 32/64, z1 for 48/96, z3 for 64/128.
- `i_clk`, in, 1: clock, rising edge.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_load`, in, 1: shift one nibble into the block/key chain.
- `i_data`, in, 4: load nibble.
- `i_start`, in, 1: begin an operation.
- `i_decrypt`, in, 1: mode, sampled with `i_start`. 0 = encrypt, 1 = decrypt.
- `o_data`, out, 4: equals `block[3:0]` (combinational from the register).
- `o_busy`, out, 1: high in EXPAND and RUN.
- `o_done`, out, 1: high in DONE.

## Operation

**Registers**
- `block[2n-1:0]` holds {x, y}, with x in the upper word.
- `key[4n-1:0]` holds the window {k(i+3), k(i+2), k(i+1), k(i)}, with k(i) in the lowest word.
- `rnd`: round counter, 6 bits.
- `mode`: latched decrypt flag.

**States:** IDLE, EXPAND, RUN, DONE.

**Load** (any state except EXPAND/RUN, with `i_load` = 1)
- The chain {block, key} shifts right by 4: `i_data` enters `key[4n-1:4n-4]` and `key[3:0]` moves into `block[2n-1:2n-4]`.
- `o_data` therefore streams out the previous block, least-significant nibble first.
- Load order: 2n/4 block nibbles, least significant first, then n key nibbles, least significant first. Total 6n/4 cycles.
- From DONE, a load moves the state to IDLE.

**Start** (IDLE or DONE, `i_start` = 1, `i_load` = 0)
- Set `rnd` = 0 and latch `mode`.
- Go to RUN if encrypting, EXPAND if decrypting.

**Key-step functions** (S^-r is right rotate by r; c = 2^n − 4)
- Forward: tmp = S^-3 k(i+3) ^ k(i+1). New k(i+4) = c ^ Z_SEQ[rnd] ^ k(i) ^ tmp ^ S^-1 tmp. The window shifts down one word.
- Backward, from window {k(i+4), k(i+3), k(i+2), k(i+1)}: tmp = S^-3 k(i+3) ^ k(i+1). New k(i) = c ^ Z_SEQ[rnd] ^ k(i+4) ^ tmp ^ S^-1 tmp. The window shifts up one word.

**EXPAND**
- One forward key step per cycle, `rnd` incrementing from 0 to T−1.
- After the step at `rnd` = T−1, the window holds {k(T+3), ..., k(T)}.
- Then set `rnd` = T−1 and go to RUN.

**RUN, encrypt**
- Each cycle: (x, y) ← (y ^ f(x) ^ k(i), x), where f(x) = (S¹x & S⁸x) ^ S²x (left rotates).
- k(i) is the low key word; do a forward key step in the same cycle. `rnd` increments.
- Go to DONE after `rnd` = T−1.

**RUN, decrypt**
- Each cycle: compute k(rnd) with the backward step, then (x, y) ← (y, x ^ f(y) ^ k(rnd)), using the newly computed word.
- Shift the key window up. `rnd` decrements.
- Go to DONE after `rnd` = 0.

**State at completion**
- After decrypt, `key` equals the loaded key exactly.
- After encrypt, `key` holds the k(T) window. A new encrypt needs a reload.

**Precedence**
- `i_load` and `i_start` are ignored while `o_busy` is high.
- If `i_load` and `i_start` are high together in IDLE/DONE, the load wins and the start is dropped.

**Reset** (`i_rst_n` low, at any time, including mid-operation)
- All registers go to 0 and the state goes to IDLE.
- Outputs: `o_data` = 0, `o_busy` = 0, `o_done` = 0.

## Timing

- Start sampled at edge E.
- Encrypt: rounds occur at edges E+1 .. E+T. `o_busy` is high from after E through E+T−1 (T cycles). `o_done` rises after edge E+T.
- Decrypt: expansion at edges E+1 .. E+T, rounds at E+T+1 .. E+2T. `o_busy` is high for 2T cycles. `o_done` rises after E+2T.
- `o_done` stays high until the next load or start.
- Readout: the ciphertext or plaintext is valid on `o_data` in DONE. 2n/4 `i_load` cycles shift it out, least significant nibble first.
- No combinational path from inputs to outputs.

## Test plan

- **32/64 encrypt.** Key 1918_1110_0908_0100, plaintext 6565_6877, 24 loads, start with `i_decrypt`=0 → `o_done` exactly 32 cycles after start, block = c69b_e9bb.
- **32/64 decrypt.** Same key, block c69b_e9bb, `i_decrypt`=1 → `o_done` 64 cycles after start, block = 6565_6877, key register equals the loaded key.
- **48/96 (WORD=24, ROUNDS=36, z1).** Key 1a1918_121110_0a0908_020100, plaintext 726963_20646e → ciphertext 6e06a5_acf156. Decrypt restores the plaintext.
- **64/128 (WORD=32, ROUNDS=44, z3).** Key 1b1a1918_13121110_0b0a0908_03020100, plaintext 656b696c_20646e75 → ciphertext 44c8fc20_b9dfa07a. Decrypt round-trips.
- **Protocol.** `i_start` or `i_load` pulsed mid-RUN → ignored, result unchanged. `i_start` and `i_load` together in IDLE → load only, `o_busy` stays 0. A load in DONE → state IDLE and `o_done` drops.
- **Reset.** Assert `i_rst_n` low at cycle 10 of a decrypt → all outputs 0 immediately. After release, a fresh load plus encrypt gives the correct ciphertext.

Source files
------------

// File: rtl/simon_param_if.sv
// Nibble-serial load/start/mode inputs and data/status outputs of the Simon core.
interface simon_param_if;
    logic       i_load;
    logic [3:0] i_data;
    logic       i_start;
    logic       i_decrypt;
    logic [3:0] o_data;
    logic       o_busy;
    logic       o_done;

    modport master (
        output i_load, i_data, i_start, i_decrypt,
        input  o_data, o_busy, o_done
    );

    modport slave (
        input  i_load, i_data, i_start, i_decrypt,
        output o_data, o_busy, o_done
    );
endinterface

// File: rtl/simon_param.sv
// Simon 2n/4n block cipher core (encrypt/decrypt) with a nibble-serial load/readout chain.
// Encrypt takes ROUNDS cycles and decrypt 2*ROUNDS cycles after start; load/start are ignored while busy.
module simon_param #(
    parameter int          WORD   = 16,
    parameter int          ROUNDS = 32,
    parameter logic [61:0] Z_SEQ  = 62'b01100111000011010100100010111110110011100001101010010001011111
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    simon_param_if.slave bus
);
    localparam int              BW   = 2 * WORD;
    localparam int              KW   = 4 * WORD;
    localparam logic [5:0]      LAST = 6'(ROUNDS - 1);
    localparam logic [WORD-1:0] C_K  = {{(WORD-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   block_q, block_d;
    logic [KW-1:0]   key_q,   key_d;
    logic [5:0]      rnd_q,   rnd_d;
    logic            mode_q,  mode_d;

    function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v, input int r);
        rol = (v << r) | (v >> (WORD - r));
    endfunction

    function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] v, input int r);
        ror = (v >> r) | (v << (WORD - r));
    endfunction

    function automatic logic [WORD-1:0] f_rnd(input logic [WORD-1:0] v);
        f_rnd = (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    logic [WORD-1:0] w0, w1, w2, w3, x_w, y_w;
    logic [WORD-1:0] zc, fwd_tmp, bwd_tmp, k_fwd, k_bwd;
    logic [KW+BW+3:0] chain_sh;

    assign w0  = key_q[WORD-1:0];
    assign w1  = key_q[2*WORD-1:WORD];
    assign w2  = key_q[3*WORD-1:2*WORD];
    assign w3  = key_q[KW-1:3*WORD];
    assign x_w = block_q[BW-1:WORD];
    assign y_w = block_q[WORD-1:0];

    // Both directions share the round constant; they differ in which words feed tmp.
    assign zc      = C_K ^ {{(WORD-1){1'b0}}, Z_SEQ[rnd_q]};
    assign fwd_tmp = ror(w3, 3) ^ w1;
    assign k_fwd   = zc ^ w0 ^ fwd_tmp ^ ror(fwd_tmp, 1);
    assign bwd_tmp = ror(w2, 3) ^ w0;
    assign k_bwd   = zc ^ w3 ^ bwd_tmp ^ ror(bwd_tmp, 1);

    assign chain_sh = {bus.i_data, key_q, block_q};

    always_comb begin
        state_d = state_q;
        block_d = block_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.i_load) begin
                    key_d   = chain_sh[KW+BW+3:BW+4];
                    block_d = chain_sh[BW+3:4];
                    state_d = S_IDLE;
                end else if (bus.i_start) begin
                    rnd_d   = 6'd0;
                    mode_d  = bus.i_decrypt;
                    state_d = bus.i_decrypt ? S_EXPAND : S_RUN;
                end
            end
            S_EXPAND: begin
                key_d = {k_fwd, key_q[KW-1:WORD]};
                if (rnd_q == LAST) begin
                    state_d = S_RUN;
                end else begin
                    rnd_d = rnd_q + 6'd1;
                end
            end
            S_RUN: begin
                if (mode_q) begin
                    block_d = {y_w, x_w ^ f_rnd(y_w) ^ k_bwd};
                    key_d   = {key_q[KW-WORD-1:0], k_bwd};
                    rnd_d   = rnd_q - 6'd1;
                    if (rnd_q == 6'd0) state_d = S_DONE;
                end else begin
                    block_d = {y_w ^ f_rnd(x_w) ^ w0, x_w};
                    key_d   = {k_fwd, key_q[KW-1:WORD]};
                    rnd_d   = rnd_q + 6'd1;
                    if (rnd_q == LAST) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            block_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            block_q <= block_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.o_data = block_q[3:0];
    assign bus.o_busy = (state_q == S_EXPAND) || (state_q == S_RUN);
    assign bus.o_done = (state_q == S_DONE);
endmodule

// File: tb/tb_simon_param.sv
// Bench for simon_param at 32/64, 48/96 and 64/128: known answers, random round trips, protocol and reset.
module tb_simon_param;
    localparam logic [61:0] Z0 = 62'b01100111000011010100100010111110110011100001101010010001011111;
    localparam logic [61:0] Z1 = 62'b01011010000110010011111011100010101101000011001001111101110001;
    localparam logic [61:0] Z3 = 62'b11110000101100111001010001001000000111101001100011010111011011;
    localparam int          NWP [3] = '{16, 24, 32};
    localparam int          NTP [3] = '{32, 36, 44};
    localparam logic [61:0] ZP  [3] = '{Z0, Z1, Z3};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       ld  [3];
    logic [3:0] dat [3];
    logic       st  [3];
    logic       dc  [3];
    logic [3:0] od  [3];
    logic       obs [3];
    logic       odn [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        simon_param_if bus ();
        simon_param #(.WORD(NWP[g]), .ROUNDS(NTP[g]), .Z_SEQ(ZP[g])) dut (
            .i_clk  (clk),
            .i_rst_n(rst_n),
            .bus    (bus.slave)
        );
        assign bus.i_load    = ld[g];
        assign bus.i_data    = dat[g];
        assign bus.i_start   = st[g];
        assign bus.i_decrypt = dc[g];
        assign od[g]         = bus.o_data;
        assign obs[g]        = bus.o_busy;
        assign odn[g]        = bus.o_done;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (plain arithmetic on the cipher definition)
    logic [63:0] mk [0:47];

    function automatic logic [63:0] rotl(input logic [63:0] v, input int r, input int n);
        logic [63:0] m;
        m = (64'h1 << n) - 64'h1;
        return ((v << r) | (v >> (n - r))) & m;
    endfunction

    function automatic logic [63:0] fm(input logic [63:0] v, input int n);
        return (rotl(v, 1, n) & rotl(v, 8, n)) ^ rotl(v, 2, n);
    endfunction

    task automatic model_keys(input int d, input logic [127:0] key);
        int n;
        logic [63:0] m, tmp;
        n = NWP[d];
        m = (64'h1 << n) - 64'h1;
        for (int i = 0; i < 4; i++) mk[i] = 64'(key >> (i * n)) & m;
        for (int i = 0; i < NTP[d]; i++) begin
            tmp = rotl(mk[i+3], n - 3, n) ^ mk[i+1];
            mk[i+4] = (~mk[i] & m) ^ tmp ^ rotl(tmp, n - 1, n) ^ 64'd3 ^ 64'(ZP[d][i]);
        end
    endtask

    task automatic model_enc(input int d, input logic [127:0] key, input logic [63:0] pt,
                             output logic [63:0] ct, output logic [127:0] kend);
        int n;
        logic [63:0] m, x, y, tmp;
        n = NWP[d];
        m = (64'h1 << n) - 64'h1;
        model_keys(d, key);
        x = (pt >> n) & m;
        y = pt & m;
        for (int i = 0; i < NTP[d]; i++) begin
            tmp = x;
            x = y ^ fm(x, n) ^ mk[i];
            y = tmp;
        end
        ct = (x << n) | y;
        kend = '0;
        for (int j = 0; j < 4; j++) kend |= 128'(mk[NTP[d]+j]) << (j * n);
    endtask

    task automatic model_dec(input int d, input logic [127:0] key, input logic [63:0] ct,
                             output logic [63:0] pt);
        int n;
        logic [63:0] m, x, y, tmp;
        n = NWP[d];
        m = (64'h1 << n) - 64'h1;
        model_keys(d, key);
        x = (ct >> n) & m;
        y = ct & m;
        for (int i = NTP[d] - 1; i >= 0; i--) begin
            tmp = y;
            y = x ^ fm(y, n) ^ mk[i];
            x = tmp;
        end
        pt = (x << n) | y;
    endtask

    // ---------------- drivers (called #1 after a rising edge)
    task automatic shift_chain(input int d, input logic [191:0] cin, input logic cdone,
                               output logic [191:0] cout);
        int nn;
        nn = 3 * NWP[d] / 2;
        cout = '0;
        for (int i = 0; i < nn; i++) begin
            ld[d] = 1'b1;
            dat[d] = cin[i*4 +: 4];
            cout[i*4 +: 4] = od[d];
            @(posedge clk); #1;
            if (cdone && i == 0) begin
                chk("done_drops_on_load", {odn[d], obs[d]}, 2'b00);
            end
        end
        ld[d] = 1'b0;
    endtask

    task automatic run_op(input int d, input logic dec, output int cyc, output logic bok);
        dc[d] = dec;
        st[d] = 1'b1;
        @(posedge clk); #1;
        st[d] = 1'b0;
        cyc = 0;
        bok = 1'b1;
        while (!odn[d] && cyc < 200) begin
            if (!obs[d]) bok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    function automatic logic [191:0] mkchain(input int d, input logic [127:0] key, input logic [63:0] blk);
        return (192'(key) << (2 * NWP[d])) | 192'(blk);
    endfunction

    task automatic do_case(input int d, input logic dec, input logic [127:0] key, input logic [63:0] din,
                           input logic [63:0] dout, input logic [127:0] kexp, input string nm);
        int cyc, n;
        logic bok;
        logic [191:0] rd, bm;
        n = NWP[d];
        bm = (192'(1) << (2 * n)) - 192'(1);
        shift_chain(d, mkchain(d, key, din), 1'b0, rd);
        run_op(d, dec, cyc, bok);
        chk({nm, "_cycles"}, 192'(cyc), dec ? 192'(2 * NTP[d]) : 192'(NTP[d]));
        chk({nm, "_busy"}, 192'(bok), 192'(1));
        shift_chain(d, '0, 1'b1, rd);
        chk({nm, "_block"}, rd & bm, 192'(dout));
        chk({nm, "_key"}, rd >> (2 * n), 192'(kexp));
    endtask

    typedef struct {
        int           d;
        logic         dec;
        logic [127:0] key;
        logic [63:0]  din;
        logic [63:0]  dout;
    } vec_t;

    vec_t vec [6];

    initial begin
        logic [127:0] key, kend;
        logic [63:0]  pt, ct, pt2;
        logic [191:0] rd;
        int           cyc;
        logic         bok;

        vec[0] = '{0, 1'b0, 128'h1918_1110_0908_0100, 64'h6565_6877, 64'hc69b_e9bb};
        vec[1] = '{0, 1'b1, 128'h1918_1110_0908_0100, 64'hc69b_e9bb, 64'h6565_6877};
        vec[2] = '{1, 1'b0, 128'h1a1918_121110_0a0908_020100, 64'h726963_20646e, 64'h6e06a5_acf156};
        vec[3] = '{1, 1'b1, 128'h1a1918_121110_0a0908_020100, 64'h6e06a5_acf156, 64'h726963_20646e};
        vec[4] = '{2, 1'b0, 128'h1b1a1918_13121110_0b0a0908_03020100, 64'h656b696c_20646e75, 64'h44c8fc20_b9dfa07a};
        vec[5] = '{2, 1'b1, 128'h1b1a1918_13121110_0b0a0908_03020100, 64'h44c8fc20_b9dfa07a, 64'h656b696c_20646e75};

        for (int i = 0; i < 3; i++) begin
            ld[i] = 1'b0; dat[i] = 4'h0; st[i] = 1'b0; dc[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_data", 192'(od[i]), 192'(0));
            chk("reset_busy_done", {obs[i], odn[i]}, 2'b00);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // known-answer table
        for (int i = 0; i < 6; i++) begin
            if (vec[i].dec) kend = vec[i].key;
            else model_enc(vec[i].d, vec[i].key, vec[i].din, ct, kend);
            do_case(vec[i].d, vec[i].dec, vec[i].key, vec[i].din, vec[i].dout, kend,
                    $sformatf("kat%0d", i));
        end

        // random round trips against the model
        for (int r = 0; r < 6; r++) begin
            int d, n;
            d = r % 3;
            n = NWP[d];
            key = {$urandom, $urandom, $urandom, $urandom} & ((128'(1) << (4 * n)) - 128'(1));
            pt  = {$urandom, $urandom} & ((64'(1) << (2 * n)) - 64'(1));
            model_enc(d, key, pt, ct, kend);
            model_dec(d, key, ct, pt2);
            do_case(d, 1'b0, key, pt, ct, kend, $sformatf("rnd_enc%0d", r));
            do_case(d, 1'b1, key, ct, pt2, key, $sformatf("rnd_dec%0d", r));
        end

        // start/load pulsed mid-run are ignored
        key = vec[0].key;
        model_enc(0, key, vec[0].din, ct, kend);
        shift_chain(0, mkchain(0, key, vec[0].din), 1'b0, rd);
        dc[0] = 1'b0; st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        cyc = 0;
        repeat (5) begin @(posedge clk); #1; cyc++; end
        ld[0] = 1'b1; st[0] = 1'b1; dc[0] = 1'b1; dat[0] = 4'hf;
        @(posedge clk); #1; cyc++;
        ld[0] = 1'b0; st[0] = 1'b0; dc[0] = 1'b0;
        while (!odn[0] && cyc < 200) begin @(posedge clk); #1; cyc++; end
        chk("midrun_cycles", 192'(cyc), 192'(32));
        shift_chain(0, '0, 1'b1, rd);
        chk("midrun_block", rd & 192'hffff_ffff, 192'(vec[0].dout));

        // load and start together in IDLE: load wins
        st[0] = 1'b1;
        shift_chain(0, mkchain(0, key, vec[0].din), 1'b0, rd);
        st[0] = 1'b0;
        chk("load_start_busy_done", {obs[0], odn[0]}, 2'b00);
        run_op(0, 1'b0, cyc, bok);
        chk("load_start_cycles", 192'(cyc), 192'(32));
        shift_chain(0, '0, 1'b1, rd);
        chk("load_start_block", rd & 192'hffff_ffff, 192'(vec[0].dout));

        // decrypt then encrypt straight from DONE
        shift_chain(0, mkchain(0, key, vec[0].dout), 1'b0, rd);
        run_op(0, 1'b1, cyc, bok);
        chk("chain_dec_cycles", 192'(cyc), 192'(64));
        run_op(0, 1'b0, cyc, bok);
        chk("chain_enc_cycles", 192'(cyc), 192'(32));
        shift_chain(0, '0, 1'b1, rd);
        chk("chain_enc_block", rd & 192'hffff_ffff, 192'(vec[0].dout));
        chk("chain_enc_key", rd >> 32, 192'(kend));

        // asynchronous reset in the middle of a decrypt
        shift_chain(0, mkchain(0, key, vec[0].dout), 1'b0, rd);
        dc[0] = 1'b1; st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        chk("pre_reset_busy", 192'(obs[0]), 192'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("midop_reset_data", 192'(od[0]), 192'(0));
        chk("midop_reset_busy_done", {obs[0], odn[0]}, 2'b00);
        dc[0] = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_case(0, 1'b0, key, vec[0].din, vec[0].dout, kend, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
